graphics_write_buffer: RTL and testbench

GRAPHICS_WRITE_BUFFER -- requirements
Module: graphics_write_buffer

---
 rtl/graphics_write_buffer_if.sv | 25 ++
 rtl/graphics_write_buffer.sv | 83 ++++++++
 tb/tb_graphics_write_buffer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/graphics_write_buffer_if.sv
// rtl/graphics_write_buffer_if.sv - CPU write port and vga_control command port of the graphics write buffer
interface graphics_write_buffer_if #(
  parameter int DATA_W = 32
);
  logic              AS_L;
  logic              WE_L;
  logic              Graphics_Select_H;
  logic [3:0]        Byte_Enable;
  logic [DATA_W-1:0] Data_In;
  logic              DTAck;
  logic [31:0]       Status_Out;
  logic [DATA_W-1:0] Vga_Data;
  logic              Vga_Start;
  logic              Vga_Ready;

  modport slave (
    input  AS_L, WE_L, Graphics_Select_H, Byte_Enable, Data_In, Vga_Ready,
    output DTAck, Status_Out, Vga_Data, Vga_Start
  );

  modport master (
    output AS_L, WE_L, Graphics_Select_H, Byte_Enable, Data_In, Vga_Ready,
    input  DTAck, Status_Out, Vga_Data, Vga_Start
  );
endinterface

// File: rtl/graphics_write_buffer.sv
// rtl/graphics_write_buffer.sv - CPU write FIFO that drains command words into vga_control
module graphics_write_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                    Clock,
  input  logic                    Reset_L,
  graphics_write_buffer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic write_cycle, pending, be_ok, full, empty, push, pop;

  // Full is taken from the registered count, so a pop in the same cycle does not unstall a write.
  always_comb begin
    write_cycle = !bus.AS_L && !bus.WE_L && bus.Graphics_Select_H;
    pending     = write_cycle && !done_q;
    be_ok       = (bus.Byte_Enable == 4'hF);
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    push        = pending && be_ok && !full;
    pop         = (state_q == ISSUE);
    count_d     = count_q + CW'(push) - CW'(pop);
    err_d       = err_q || (pending && !be_ok);
    done_d      = bus.AS_L ? 1'b0 : (done_q || (pending && (!be_ok || !full)));
  end

  always_comb begin
    state_d    = state_q;
    vga_data_d = vga_data_q;
    case (state_q)
      IDLE: begin
        if (!empty && bus.Vga_Ready) begin
          state_d    = ISSUE;
          vga_data_d = mem_q[rd_ptr_q];
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.Vga_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vga_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vga_data_q <= vga_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.Data_In;
  end

  assign bus.DTAck      = !Reset_L || !(pending && be_ok && full);
  assign bus.Vga_Start  = (state_q == ISSUE);
  assign bus.Vga_Data   = vga_data_q;
  assign bus.Status_Out = {16'h0, 8'(count_q), 5'h0, err_q, full, empty};
endmodule

// File: tb/tb_graphics_write_buffer.sv
// tb/tb_graphics_write_buffer.sv - self-checking bench for graphics_write_buffer
module tb_graphics_write_buffer;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  graphics_write_buffer_if #(.DATA_W(DW)) bus();
  graphics_write_buffer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .Clock   (clk),
    .Reset_L (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // vga_control stand-in: drops Vga_Ready for busy_len cycles after each Vga_Start.
  logic ready_en  = 1'b0;
  int   busy      = 0;
  int   busy_len  = 1;
  logic saw_start = 1'b0;
  assign bus.Vga_Ready = ready_en && (busy == 0);
  always @(negedge clk) saw_start = bus.Vga_Start;
  always @(posedge clk) begin
    #1;
    if (saw_start) busy = busy_len;
    else if (busy > 0) busy--;
  end

  // Reference model: a queue of accepted words plus the drain rules.
  logic [DW-1:0] mq[$];
  logic          m_err   = 1'b0;
  logic          m_done  = 1'b0;
  int            m_phase = 0;
  logic [DW-1:0] m_vdata = '0;
  int            n_deliv = 0;
  int            n_coin  = 0;
  int            sz;
  logic          wc, pend, beok, do_push, do_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_err = 1'b0; m_done = 1'b0; m_phase = 0; m_vdata = '0;
    end else begin
      sz      = mq.size();
      wc      = !bus.AS_L && !bus.WE_L && bus.Graphics_Select_H;
      pend    = wc && !m_done;
      beok    = (bus.Byte_Enable == 4'hF);
      do_push = pend && beok && (sz < DEPTH);
      do_pop  = (m_phase == 1);
      if (pend && !beok) m_err = 1'b1;
      if (bus.AS_L) m_done = 1'b0;
      else if (pend && (!beok || sz < DEPTH)) m_done = 1'b1;
      if (m_phase == 0) begin
        if (sz > 0 && bus.Vga_Ready) begin
          m_phase = 1;
          m_vdata = mq[0];
        end
      end else if (m_phase == 1) m_phase = 2;
      else if (bus.Vga_Ready) m_phase = 0;
      if (do_pop) begin
        void'(mq.pop_front());
        n_deliv++;
      end
      if (do_push) mq.push_back(bus.Data_In);
      if (do_push && do_pop) n_coin++;
    end
  end

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(mq.size()), 5'h0, m_err, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  function automatic logic exp_dtack();
    if (!rst_n) return 1'b1;
    return !(!bus.AS_L && !bus.WE_L && bus.Graphics_Select_H && !m_done
             && bus.Byte_Enable == 4'hF && mq.size() == DEPTH);
  endfunction

  logic [DW-1:0] got[$];
  always @(negedge clk) begin
    chk("cmp_dtack", 32'(bus.DTAck), 32'(exp_dtack()));
    chk("cmp_status", bus.Status_Out, exp_status());
    chk("cmp_start", 32'(bus.Vga_Start), 32'(m_phase == 1));
    chk("cmp_vdata", bus.Vga_Data, m_vdata);
    if (bus.Vga_Start) got.push_back(bus.Vga_Data);
  end

  task automatic cpu_write(input logic [31:0] d, input logic [3:0] be, input int hold, output int stalls);
    @(posedge clk); #1;
    bus.AS_L = 1'b0; bus.WE_L = 1'b0; bus.Graphics_Select_H = 1'b1;
    bus.Byte_Enable = be; bus.Data_In = d;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (bus.DTAck) break;
      stalls++;
      if (stalls > 200) begin
        chk("write_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    repeat (hold + 1) @(posedge clk);
    #1;
    bus.AS_L = 1'b1; bus.WE_L = 1'b1; bus.Graphics_Select_H = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.AS_L = 1'b1; bus.WE_L = 1'b1; bus.Graphics_Select_H = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (bus.Status_Out != 32'h1 || m_phase != 0) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        chk(name, bus.Status_Out, 32'h1);
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int starts;
    bus.AS_L = 1'b1; bus.WE_L = 1'b1; bus.Graphics_Select_H = 1'b0;
    bus.Byte_Enable = 4'hF; bus.Data_In = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_status", bus.Status_Out, 32'h0000_0001);
    chk("rst_dtack", 32'(bus.DTAck), 32'd1);
    chk("rst_start", 32'(bus.Vga_Start), 32'd0);
    chk("rst_vdata", bus.Vga_Data, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single write, latency N+2
    ready_en = 1'b1; busy_len = 2;
    repeat (2) @(posedge clk);
    cpu_write(32'h00A5_1234, 4'hF, 0, st);
    chk("single_nostall", 32'(st), 32'd0);
    @(negedge clk);
    chk("single_n1_start", 32'(bus.Vga_Start), 32'd0);
    chk("single_n1_status", bus.Status_Out, 32'h0000_0100);
    @(negedge clk);
    chk("single_n2_start", 32'(bus.Vga_Start), 32'd1);
    chk("single_n2_data", bus.Vga_Data, 32'h00A5_1234);
    @(negedge clk);
    chk("single_after_status", bus.Status_Out, 32'h0000_0001);
    wait_empty("single_drain");

    // Fill to DEPTH with Vga_Ready low, then a stalled ninth write
    do_reset();
    ready_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cpu_write(32'h100 + 32'(i), 4'hF, 0, st);
      chk("fill_nostall", 32'(st), 32'd0);
    end
    @(negedge clk);
    chk("fill_status", bus.Status_Out, 32'h0000_0802);
    chk("model_fill_cnt", 32'(mq.size()), 32'd8);
    @(posedge clk); #1;
    bus.AS_L = 1'b0; bus.WE_L = 1'b0; bus.Graphics_Select_H = 1'b1;
    bus.Data_In = 32'h108;
    repeat (3) begin
      @(negedge clk);
      chk("ninth_stall", 32'(bus.DTAck), 32'd0);
    end
    @(posedge clk); #1 ready_en = 1'b1;
    @(negedge clk);
    chk("ninth_m0_dtack", 32'(bus.DTAck), 32'd0);
    @(negedge clk);
    chk("ninth_m1_start", 32'(bus.Vga_Start), 32'd1);
    chk("ninth_m1_dtack", 32'(bus.DTAck), 32'd0);
    chk("ninth_m1_data", bus.Vga_Data, 32'h100);
    @(negedge clk);
    chk("ninth_m2_dtack", 32'(bus.DTAck), 32'd1);
    chk("ninth_m2_status", bus.Status_Out, 32'h0000_0700);
    @(posedge clk); #1;
    bus.AS_L = 1'b1; bus.WE_L = 1'b1; bus.Graphics_Select_H = 1'b0;
    @(negedge clk);
    chk("ninth_refill", bus.Status_Out, 32'h0000_0802);
    wait_empty("fill_drain");

    // AS_L held low for five cycles pushes once
    do_reset();
    ready_en = 1'b0;
    cpu_write(32'hDEAD_0001, 4'hF, 4, st);
    @(negedge clk);
    chk("hold_once", bus.Status_Out, 32'h0000_0100);

    // Partial byte enables: acknowledged, not pushed, sticky error
    cpu_write(32'hBAD0_BAD0, 4'b0011, 0, st);
    chk("be_nostall", 32'(st), 32'd0);
    @(negedge clk);
    chk("be_status", bus.Status_Out, 32'h0000_0104);
    cpu_write(32'hDEAD_0002, 4'hF, 0, st);
    @(negedge clk);
    chk("be_sticky", bus.Status_Out, 32'h0000_0204);
    do_reset();
    @(negedge clk);
    chk("be_cleared", bus.Status_Out, 32'h0000_0001);

    // Stream of 20 words with varying vga_control busy time
    ready_en = 1'b1;
    got.delete();
    n_coin = 0;
    for (int i = 0; i < 20; i++) begin
      busy_len = 1 + (i % 3);
      cpu_write(32'(i), 4'hF, 0, st);
    end
    wait_empty("stream_drain");
    chk("stream_count", 32'(got.size()), 32'd20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("stream_order", got[i], 32'(i));
    chk("stream_coincide", 32'(n_coin > 0), 32'd1);

    // Reset pulse while in WAIT with three words buffered
    do_reset();
    ready_en = 1'b0; busy_len = 10;
    for (int i = 0; i < 4; i++) cpu_write(32'h200 + 32'(i), 4'hF, 0, st);
    @(posedge clk); #1 ready_en = 1'b1;
    st = 0;
    do begin
      @(negedge clk);
      st++;
    end while (!bus.Vga_Start && st < 50);
    chk("wait_saw_start", 32'(bus.Vga_Start), 32'd1);
    @(negedge clk);
    chk("wait_status", bus.Status_Out, 32'h0000_0300);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_start", 32'(bus.Vga_Start), 32'd0);
    chk("rstmid_status", bus.Status_Out, 32'h0000_0001);
    chk("rstmid_dtack", 32'(bus.DTAck), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.Vga_Start) starts++;
    end
    chk("rstmid_nostart", 32'(starts), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
